// File: rtl/nav_frame_tx.sv
// nav_frame_tx: serialises one navigation solution into a framed byte stream
// (SYNC0 SYNC1, 10 payload bytes, optional XOR checksum when NAV_TX_CHECKSUM_EN is defined).
module nav_frame_tx #(
  parameter logic [7:0]  SYNC0    = 8'hB5,
  parameter logic [7:0]  SYNC1    = 8'h62,
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] position,
  input  logic [31:0] velocity,
  input  logic        alert,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC0   = 3'd1;
  localparam logic [2:0] ST_SYNC1   = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CSUM    = 3'd4;
  localparam logic [2:0] ST_GAP     = 3'd5;

  // Where the FSM goes once the last byte of a frame has been accepted.
  localparam logic [2:0] ST_AFTER = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
  localparam logic [7:0] GAP_LAST = 8'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);

  logic [2:0]  r_state;
  logic [3:0]  r_idx;
  logic [7:0]  r_seq;
  logic [15:0] r_frames;
  logic [7:0]  r_gap_cnt;
  logic [31:0] r_pos;
  logic [31:0] r_vel;
  logic        r_alert;
  logic [7:0]  r_seq_lat;
`ifdef NAV_TX_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic       w_accept;
  logic       w_xfer;
  logic       w_last_xfer;
  logic [7:0] w_payload_byte;

  assign s_ready     = (r_state == ST_IDLE) && !rst;
  assign busy        = (r_state != ST_IDLE);
  assign frames_sent = r_frames;
  assign w_accept    = s_valid && s_ready;
  assign w_xfer      = m_valid && m_ready;

`ifdef NAV_TX_CHECKSUM_EN
  assign w_last_xfer = w_xfer && (r_state == ST_CSUM);
`else
  assign w_last_xfer = w_xfer && (r_state == ST_PAYLOAD) && (r_idx == 4'd9);
`endif

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_payload_byte = 8'h00;
    case (r_idx)
      4'd0:    w_payload_byte = {7'b0, r_alert};
      4'd1:    w_payload_byte = r_pos[31:24];
      4'd2:    w_payload_byte = r_pos[23:16];
      4'd3:    w_payload_byte = r_pos[15:8];
      4'd4:    w_payload_byte = r_pos[7:0];
      4'd5:    w_payload_byte = r_vel[31:24];
      4'd6:    w_payload_byte = r_vel[23:16];
      4'd7:    w_payload_byte = r_vel[15:8];
      4'd8:    w_payload_byte = r_vel[7:0];
      4'd9:    w_payload_byte = r_seq_lat;
      default: w_payload_byte = 8'h00;
    endcase
  end

  always_comb begin
    m_valid = 1'b0;
    m_data  = 8'h00;
    case (r_state)
      ST_SYNC0:   begin m_valid = 1'b1; m_data = SYNC0;          end
      ST_SYNC1:   begin m_valid = 1'b1; m_data = SYNC1;          end
      ST_PAYLOAD: begin m_valid = 1'b1; m_data = w_payload_byte; end
`ifdef NAV_TX_CHECKSUM_EN
      ST_CSUM:    begin m_valid = 1'b1; m_data = r_csum;         end
`endif
      default:    begin m_valid = 1'b0; m_data = 8'h00;          end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= 4'd0;
      r_seq     <= 8'h00;
      r_frames  <= 16'h0000;
      r_gap_cnt <= 8'h00;
`ifdef NAV_TX_CHECKSUM_EN
      r_csum    <= 8'h00;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_SYNC0;
            r_idx   <= 4'd0;
`ifdef NAV_TX_CHECKSUM_EN
            r_csum  <= 8'h00;
`endif
          end
        end
        ST_SYNC0: if (m_ready) r_state <= ST_SYNC1;
        ST_SYNC1: if (m_ready) r_state <= ST_PAYLOAD;
        ST_PAYLOAD: begin
          if (m_ready) begin
`ifdef NAV_TX_CHECKSUM_EN
            r_csum <= r_csum ^ w_payload_byte;
`endif
            if (r_idx == 4'd9) begin
              r_idx <= 4'd0;
`ifdef NAV_TX_CHECKSUM_EN
              r_state <= ST_CSUM;
`else
              r_state <= ST_AFTER;
`endif
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
`ifdef NAV_TX_CHECKSUM_EN
        ST_CSUM: if (m_ready) r_state <= ST_AFTER;
`endif
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= 8'h00;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'h01;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_last_xfer) begin
        r_seq    <= r_seq + 8'h01;
        r_frames <= r_frames + 16'h0001;
      end
    end
  end

  // NOTE: shadow registers carry no reset; they are always loaded on accept before being read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pos     <= position;
      r_vel     <= velocity;
      r_alert   <= alert;
      r_seq_lat <= r_seq;
    end
  end

endmodule

// File: doc/nav_frame_tx.md
Name: nav_frame_tx

Overview:
Serialises one navigation solution (position, velocity, alert) into a framed byte stream: sync word, 10-byte payload, optional checksum.
- Transmit-side counterpart of the GPS input interface. Sits after nav_processor / intrusion_detector.
- Feeds a UART or host link through a valid/ready byte port.
- Captures one solution per frame and holds it stable until the last byte is accepted.

Parameters:
SYNC0, 8'hB5, first sync byte of every frame
SYNC1, 8'h62, second sync byte of every frame
IDLE_GAP, 0, idle cycles forced after each frame before s_ready reasserts (0..255)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
s_valid  input  1  solution available
s_ready  output  1  block can accept a solution
position  input  32  position word, sampled on s_valid&&s_ready
velocity  input  32  velocity word, sampled on s_valid&&s_ready
alert  input  1  intrusion flag, sampled on s_valid&&s_ready
m_data  output  8  current frame byte
m_valid  output  1  m_data valid
m_ready  input  1  downstream accepts byte
busy  output  1  frame in progress (any state except IDLE)
frames_sent  output  16  count of completed frames; wraps at 0xFFFF->0x0000

Behaviour:
- Reset values (asserted in the same edge as rst=1):
  - state=IDLE; m_valid=0; m_data=0x00; busy=0; frames_sent=0; seq=0x00; gap counter=0.
  - s_ready=0 while rst=1; s_ready is 1 in the first cycle after rst deasserts.
- States: IDLE -> SYNC0 -> SYNC1 -> PAYLOAD -> CSUM -> GAP -> IDLE.
  - CSUM exists only when the optional feature is enabled.
  - GAP is skipped when IDLE_GAP=0.
- IDLE:
  - s_ready=1.
  - On s_valid&&s_ready: latch position, velocity, alert and current seq into shadow registers; go to SYNC0.
  - The next cycle drives m_valid=1, m_data=SYNC0. Latency from accept to first byte is 1 cycle.
- Byte handshake:
  - A byte transfers on m_valid&&m_ready.
  - While m_valid=1 and m_ready=0, m_data and state hold.
  - m_valid never drops mid-frame except on reset.
  - Bytes go back-to-back when m_ready stays high: one byte per cycle.
- PAYLOAD: 4-bit index 0..9 drives the bytes below. The index advances on each transfer; after byte 9 transfers, go to CSUM (or GAP/IDLE).
  - 0: flags = {7'b0, alert}
  - 1-4: position[31:24], [23:16], [15:8], [7:0] (big-endian)
  - 5-8: velocity, big-endian
  - 9: seq
- Inputs changing after capture do not affect the frame in flight.
- seq:
  - 8-bit; increments by 1 when the last byte of a frame transfers.
  - Wraps 0xFF -> 0x00.
  - The first frame after reset carries seq=0x00.
- frames_sent increments in the same cycle as seq.
- m_valid deasserts in the cycle after the last byte transfers.
- GAP:
  - m_valid=0, s_ready=0.
  - Counts IDLE_GAP cycles, then goes to IDLE.
- s_ready is low in every state except IDLE, so there is no capture while busy.
- Reset mid-frame: the frame is aborted with no trailing bytes; the next frame starts at SYNC0 with seq=0x00.

Optional Feature:
Macro NAV_TX_CHECKSUM_EN.
- Defined:
  - After payload byte 9, CSUM emits the XOR of payload bytes 0-9.
  - The checksum accumulates as bytes transfer, not combinationally over the shadow registers.
  - Frame length is 13 bytes.
- Undefined:
  - No CSUM state and no accumulator logic.
  - Frame length is 12 bytes.
  - Frame ends after the seq byte.

Test Plan:
1. Basic frame, checksum enabled, m_ready=1. Stimulus: reset, then position=0x12345678, velocity=0x0000ABCD, alert=1. Response:
   - stream B5 62 01 12 34 56 78 00 00 AB CD 00 6F on 13 consecutive cycles;
   - first byte 1 cycle after accept;
   - frames_sent=1.
2. Second frame: position=0, velocity=0, alert=0 -> stream B5 62 00 00 00 00 00 00 00 00 00 01 01 (seq=01); s_ready=0 for the whole frame.
3. Backpressure: m_ready low 5 cycles at payload byte 3 (0x56) -> m_data holds 0x56 with m_valid=1. Also change position mid-frame -> frame bytes unchanged.
4. Reset at payload byte 6 -> m_valid=0 after the edge. The next frame starts with B5 62 and carries seq byte 00; frames_sent=0.
5. Seq wrap: send 257 frames -> frame 256 carries seq FF, frame 257 carries seq 00; frames_sent=257.
6. IDLE_GAP=3 -> s_ready stays 0 for exactly 3 cycles after the last byte transfers, then returns to 1. With NAV_TX_CHECKSUM_EN undefined, scenario 1 yields 12 bytes ending in 00.
